// File: rtl/start_rdy_timer_pkg.sv
// Shared types and constants for the START/RDY controller/timer pair.
// Both sides of the handshake use the same constants, so they agree on polarity.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic START_REQ = 1'b1;
    localparam logic RDY_BUSY  = 1'b0;
    localparam logic RDY_FREE  = 1'b1;

    // Prescaler width; at least one bit even when DIV is 1 or 2.
    function automatic int PRE_W(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/start_rdy_timer_if.sv
// START/RDY handshake bundle between the controller (master) and the timer (slave).
interface start_rdy_timer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             abort;
    logic             rdy;
    logic             done;
    logic [WIDTH-1:0] remaining;

    modport master (
        output start, load_val, abort,
        input  rdy, done, remaining
    );

    modport slave (
        input  start, load_val, abort,
        output rdy, done, remaining
    );
endinterface

// File: rtl/start_rdy_timer_tick_gen.sv
// DIV-cycle prescaler: tick marks the last cycle of each DIV-cycle period while enabled.
// The counter parks at zero whenever it is not enabled.
module tick_gen
    import timer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int            PW      = PRE_W(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre <= '0;
        else if (clear)
            pre <= PRE_MAX;
        else if (en)
            pre <= (pre == '0) ? PRE_MAX : pre - PW'(1);
        else
            pre <= '0;
    end

    assign tick = en && (pre == '0);

endmodule

// File: rtl/start_rdy_timer.sv
// Retriggerable one-shot countdown timer closing the controller's START/RDY loop.
// rdy, done and remaining decode from registers only.
module start_rdy_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    start_rdy_timer_if.slave      bus
);

    timer_state_t     state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic             start_req;
    logic             load;
    logic             tick;

    assign start_req = (bus.start == START_REQ);
    assign load      = !bus.abort && start_req && (bus.load_val != '0);

    // Prescaler is held at zero outside RUN and on abort; a load restarts its period.
    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .en    ((state == RUN) && !bus.abort),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Abort beats start, and start beats expiry on the same edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (bus.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (start_req) begin
            if (bus.load_val != '0) begin
                state_n = RUN;
                cnt_n   = bus.load_val;
            end else begin
                state_n = DONE;
                cnt_n   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        if (cnt > WIDTH'(1)) begin
                            cnt_n = cnt - WIDTH'(1);
                        end else begin
                            state_n = DONE;
                            cnt_n   = '0;
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.rdy       = (state == RUN) ? RDY_BUSY : RDY_FREE;
    assign bus.done      = (state == DONE);
    assign bus.remaining = cnt;

endmodule
